aurora_tx_scheduler: RTL and testbench
======================================

AURORA_TX_SCHEDULER -- requirements
Module: aurora_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, 4, number of TS packet requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter PAYLOAD_WORDS, 94, 16-bit TS words per frame (188 bytes).
REQ-003 SHALL have parameter PKT_TYPE, 16'h8001, header word 0.
REQ-004 SHALL have parameter PKT_LEN, 16'h00bc, header word 2.
REQ-005 SHALL have USER_CLK input 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have RESET input 1: asynchronous, active-high reset.
REQ-007 SHALL have CHANNEL_UP input 1: Aurora lane/channel up.
REQ-008 SHALL have src_req input 4: a full packet is ready at requester i.
REQ-009 SHALL have src_data input 64: FWFT word of requester i on bits [16i+15:16i].
REQ-010 SHALL have src_rd output 4: one-hot pop of the granted requester.
REQ-011 SHALL have src_abort output 4: one-cycle pulse that discards the granted requester's partial packet.
REQ-012 SHALL have TX_D output [0:15], TX_REM output 1, TX_SOF_N output 1, TX_EOF_N output 1 and TX_SRC_RDY_N output 1: LocalLink TX.
REQ-013 SHALL have TX_DST_RDY_N input 1: LocalLink back-pressure.
REQ-014 SHALL have busy output 1 (frame in progress) and cur_chn output 2 (granted index).

Function
REQ-015 SHALL implement FSM states IDLE, HDR0, HDR1, HDR2, PAYLOAD.
REQ-016 IDLE -> HDR0 SHALL occur when CHANNEL_UP=1 and src_req!=0; grant is latched round-robin, searching from last_grant+1 mod 4.
REQ-017 Grant-to-SOF latency SHALL be one cycle: TX_SOF_N=0 is driven in the cycle after the IDLE decision.
REQ-018 A word SHALL be transferred only when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0; otherwise all TX outputs hold.
REQ-019 HDR0 SHALL drive PKT_TYPE with TX_SOF_N=0.
REQ-020 HDR1 SHALL drive {9'b0,3'b000,2'b00,cur_chn} (dst channel = grant index).
REQ-021 HDR2 SHALL drive PKT_LEN.
REQ-022 PAYLOAD SHALL pass the granted src_data word, assert src_rd[grant] only on transfer, and count PAYLOAD_WORDS words with a 7-bit counter.
REQ-023 The last payload word SHALL carry TX_EOF_N=0; after its transfer the FSM SHALL enter IDLE (one mandatory idle cycle between frames).
REQ-024 TX_SRC_RDY_N SHALL be 0 in every non-IDLE state; TX_REM SHALL be constant 1.
REQ-025 src_req deassertion mid-frame SHALL be ignored; grant changes only in IDLE.
REQ-026 On CHANNEL_UP falling mid-frame, the FSM SHALL go to IDLE next cycle, deassert TX_SRC_RDY_N, pulse src_abort[grant] for one cycle, and keep last_grant unchanged.
REQ-027 Simultaneous EOF transfer and CHANNEL_UP fall SHALL complete the frame normally with no abort.

Reset
REQ-028 On RESET: state=IDLE; TX_SRC_RDY_N=1, TX_SOF_N=1, TX_EOF_N=1, TX_D=0, TX_REM=1; src_rd=0, src_abort=0, busy=0, cur_chn=0, last_grant=3 (so that requester 0 wins first).
REQ-029 Reset asserted mid-frame SHALL abandon the frame without an abort pulse; the upstream is reset by the same RESET.

Configuration
REQ-030 Macro AURORA_TX_STAT_EN defined SHALL add outputs tx_pkt_cnt[15:0] (+1 per EOF transfer) and tx_abort_cnt[15:0] (+1 per abort), both wrapping at 16'hFFFF to 0 and reset to 0.
REQ-031 Without AURORA_TX_STAT_EN these ports and counters SHALL be absent.

Structure
REQ-032 The shared package aurora_tx_pkg SHALL hold the FSM state encoding, PKT_TYPE/PKT_LEN defaults and PAYLOAD_WORDS.
REQ-033 The round-robin arbiter SHALL be the sub-module aurora_tx_rr_arb (req[3:0], last[1:0] -> grant[1:0], valid).

Verification
REQ-034 Reset, then src_req=4'b0001 with payload words 0x0606.. -> frame 8001,0000,00bc, then 94 words; SOF on word 1, EOF on word 97; src_rd pulses 94 times.
REQ-035 src_req=4'b1111 held -> frames are granted to channels 0,1,2,3,0 in order; HDR1 = 0000,0001,0002,0003,0000; one idle cycle between frames.
REQ-036 TX_DST_RDY_N=1 for 5 cycles at payload word 10 -> TX_D, TX_EOF_N and src_rd hold; no word is lost or duplicated.
REQ-037 CHANNEL_UP drops at payload word 50 of channel 2 -> src_abort=4'b0100 for one cycle and IDLE; after recovery channel 3 is granted next.
REQ-038 With AURORA_TX_STAT_EN, 3 complete frames and 1 abort -> tx_pkt_cnt=3, tx_abort_cnt=1; a preset of 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/aurora_tx_pkg.sv
// Shared encodings and defaults for the Aurora TX packet scheduler.
package aurora_tx_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR0    = 3'd1;
    localparam logic [2:0] ST_HDR1    = 3'd2;
    localparam logic [2:0] ST_HDR2    = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;

    localparam int          PAYLOAD_WORDS_DEF = 94;
    localparam logic [15:0] PKT_TYPE_DEF      = 16'h8001;
    localparam logic [15:0] PKT_LEN_DEF       = 16'h00bc;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/aurora_tx_rr_arb.sv
// Four-way round-robin arbiter: the search starts at last+1 and wraps, so last has lowest priority.
module aurora_tx_rr_arb (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = last;
        valid = 1'b0;
        // Descending offset so the nearest requester after last is the final assignment.
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                grant = last + 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aurora_tx_scheduler.sv
// Round-robin TS packet scheduler onto an Aurora LocalLink TX port (3 header words + payload).
// Optional counters are enabled with `define AURORA_TX_STAT_EN.
module aurora_tx_scheduler
    import aurora_tx_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter int          PAYLOAD_WORDS = PAYLOAD_WORDS_DEF,
    parameter logic [15:0] PKT_TYPE      = PKT_TYPE_DEF,
    parameter logic [15:0] PKT_LEN       = PKT_LEN_DEF
) (
    input  logic                    USER_CLK,
    input  logic                    RESET,
    input  logic                    CHANNEL_UP,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [16*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_rd,
    output logic [NUM_SRC-1:0]      src_abort,
    output logic [0:15]             TX_D,
    output logic                    TX_REM,
    output logic                    TX_SOF_N,
    output logic                    TX_EOF_N,
    output logic                    TX_SRC_RDY_N,
    input  logic                    TX_DST_RDY_N,
    output logic                    busy,
    output logic [1:0]              cur_chn
`ifdef AURORA_TX_STAT_EN
    ,
    output logic [15:0]             tx_pkt_cnt,
    output logic [15:0]             tx_abort_cnt
`endif
);

    localparam logic [6:0] LAST_IDX = 7'(PAYLOAD_WORDS - 1);

    logic [2:0]  state, state_nx;
    logic [1:0]  last_grant;
    logic [6:0]  wcnt;
    logic [1:0]  arb_grant;
    logic        arb_valid;
    logic        xfer, last_word, eof_xfer, drop;
    logic [15:0] tx_word;

    aurora_tx_rr_arb u_arb (
        .req   (src_req),
        .last  (last_grant),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign xfer      = (state != ST_IDLE) && !TX_DST_RDY_N;
    assign last_word = (state == ST_PAYLOAD) && (wcnt == LAST_IDX);
    assign eof_xfer  = xfer && last_word;
    // A channel drop coinciding with the EOF transfer lets the frame finish cleanly.
    assign drop      = (state != ST_IDLE) && !CHANNEL_UP && !eof_xfer;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (CHANNEL_UP && arb_valid) state_nx = ST_HDR0;
            ST_HDR0:    if (xfer) state_nx = ST_HDR1;
            ST_HDR1:    if (xfer) state_nx = ST_HDR2;
            ST_HDR2:    if (xfer) state_nx = ST_PAYLOAD;
            ST_PAYLOAD: if (eof_xfer) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (drop) state_nx = ST_IDLE;
    end

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cur_chn    <= 2'd0;
            last_grant <= 2'd3;
            wcnt       <= 7'd0;
            src_abort  <= '0;
        end else begin
            state     <= state_nx;
            src_abort <= drop ? onehot4(cur_chn) : 4'b0000;
            if (state == ST_IDLE && CHANNEL_UP && arb_valid) begin
                cur_chn    <= arb_grant;
                last_grant <= arb_grant;
            end
            if (state == ST_HDR2 && xfer)
                wcnt <= 7'd0;
            else if (state == ST_PAYLOAD && xfer)
                wcnt <= wcnt + 7'd1;
        end
    end

    // Payload is the upstream FWFT head, which only advances on src_rd, so it holds under stall.
    always_comb begin
        case (state)
            ST_HDR0:    tx_word = PKT_TYPE;
            ST_HDR1:    tx_word = {9'b0, 3'b000, 2'b00, cur_chn};
            ST_HDR2:    tx_word = PKT_LEN;
            ST_PAYLOAD: tx_word = src_data[cur_chn*16 +: 16];
            default:    tx_word = 16'h0000;
        endcase
    end

    assign TX_D         = tx_word;
    assign TX_REM       = 1'b1;
    assign TX_SRC_RDY_N = (state == ST_IDLE);
    assign TX_SOF_N     = (state != ST_HDR0);
    assign TX_EOF_N     = !last_word;
    assign src_rd       = (state == ST_PAYLOAD && xfer) ? onehot4(cur_chn) : 4'b0000;
    assign busy         = (state != ST_IDLE);

`ifdef AURORA_TX_STAT_EN
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            tx_pkt_cnt   <= 16'd0;
            tx_abort_cnt <= 16'd0;
        end else begin
            if (eof_xfer) tx_pkt_cnt   <= tx_pkt_cnt + 16'd1;
            if (drop)     tx_abort_cnt <= tx_abort_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Scoreboard bench for aurora_tx_scheduler: stimulus queues expected TX words, a monitor pops on transfer.
module tb_aurora_tx_scheduler;

    typedef struct {
        logic        sof;
        logic        eof;
        logic        rd;
        logic [1:0]  ch;
        logic [15:0] d;
    } exp_t;

    logic        USER_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CHANNEL_UP = 1'b1;
    logic [3:0]  src_req = 4'b0000;
    logic [63:0] src_data;
    logic [3:0]  src_rd, src_abort;
    logic [0:15] TX_D;
    logic        TX_REM, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N;
    logic        TX_DST_RDY_N = 1'b0;
    logic        busy;
    logic [1:0]  cur_chn;
`ifdef AURORA_TX_STAT_EN
    logic [15:0] tx_pkt_cnt, tx_abort_cnt;
`endif

    aurora_tx_scheduler dut (
        .USER_CLK     (USER_CLK),
        .RESET        (RESET),
        .CHANNEL_UP   (CHANNEL_UP),
        .src_req      (src_req),
        .src_data     (src_data),
        .src_rd       (src_rd),
        .src_abort    (src_abort),
        .TX_D         (TX_D),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .busy         (busy),
        .cur_chn      (cur_chn)
`ifdef AURORA_TX_STAT_EN
        ,
        .tx_pkt_cnt   (tx_pkt_cnt),
        .tx_abort_cnt (tx_abort_cnt)
`endif
    );

    always #5 USER_CLK = ~USER_CLK;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   eof_seen = 0;
    int   cyc = 0;
    int   last_eof_cyc = 0;
    bit   have_eof = 0;
    bit   gap_chk = 0;
    int   exp_pkt[4];

    // Upstream FWFT model: word w of packet p on channel c.
    int w[4], pkt[4], rd_cnt[4];

    function automatic logic [15:0] pw(input int c, input int p, input int wi);
        return 16'h0606 + 16'(c << 12) + 16'(p << 8) + 16'(wi);
    endfunction

    always_comb begin
        src_data = '0;
        for (int c = 0; c < 4; c++) src_data[16*c +: 16] = pw(c, pkt[c], w[c]);
    end

    always @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < 4; c++) begin
                w[c] <= 0; pkt[c] <= 0; rd_cnt[c] <= 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (src_abort[c]) begin
                    w[c] <= 0; pkt[c] <= pkt[c] + 1;
                end else if (src_rd[c]) begin
                    rd_cnt[c] <= rd_cnt[c] + 1;
                    if (w[c] == 93) begin
                        w[c] <= 0; pkt[c] <= pkt[c] + 1;
                    end else begin
                        w[c] <= w[c] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input int c, input int nwords);
        exp_t e;
        e = '{sof: 1'b1, eof: 1'b0, rd: 1'b0, ch: 2'(c), d: 16'h8001};
        q.push_back(e);
        e.sof = 1'b0; e.d = 16'(c);
        q.push_back(e);
        e.d = 16'h00bc;
        q.push_back(e);
        for (int i = 0; i < nwords; i++) begin
            e.rd = 1'b1; e.eof = (i == 93); e.d = pw(c, exp_pkt[c], i);
            q.push_back(e);
        end
        exp_pkt[c]++;
    endtask

    task automatic tick();
        @(posedge USER_CLK); #1;
    endtask

    task automatic wait_eofs(input int target);
        int n = 0;
        while (eof_seen < target && n < 3000) begin tick(); n++; end
        check("eof_wait", 32'(eof_seen), 32'(target));
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        check("busy_wait", 32'(busy), 32'd1);
    endtask

    // Monitor: every transfer pops one expected word; src_rd must only fire on payload transfers.
    initial begin
        exp_t e;
        forever begin
            @(negedge USER_CLK);
            cyc++;
            if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual %0h required none", TX_D);
                end else begin
                    e = q.pop_front();
                    check("tx_d", 32'(TX_D), 32'(e.d));
                    check("sof_n", 32'(TX_SOF_N), 32'(!e.sof));
                    check("eof_n", 32'(TX_EOF_N), 32'(!e.eof));
                    check("src_rd", 32'(src_rd), e.rd ? 32'(4'b0001 << e.ch) : 32'd0);
                    if (e.sof && gap_chk && have_eof)
                        check("idle_gap", 32'(cyc - last_eof_cyc), 32'd2);
                    if (e.eof) begin
                        eof_seen++; last_eof_cyc = cyc; have_eof = 1;
                    end
                end
            end else begin
                check("src_rd_idle", 32'(src_rd), 32'd0);
            end
        end
    end

    initial begin
        int n;
        int p;
        for (int c = 0; c < 4; c++) exp_pkt[c] = 0;
        repeat (3) tick();
        check("rst_src_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
        check("rst_sof_n", 32'(TX_SOF_N), 32'd1);
        check("rst_eof_n", 32'(TX_EOF_N), 32'd1);
        check("rst_tx_d", 32'(TX_D), 32'd0);
        check("rst_tx_rem", 32'(TX_REM), 32'd1);
        check("rst_src_rd", 32'(src_rd), 32'd0);
        check("rst_src_abort", 32'(src_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_chn", 32'(cur_chn), 32'd0);
        RESET = 1'b0;
        tick();

        // Single requester, deasserted mid-frame (ignored).
        push_frame(0, 94);
        src_req = 4'b0001;
        tick();
        check("sof_latency", 32'(TX_SOF_N), 32'd0);
        wait_busy();
        src_req = 4'b0000;
        wait_eofs(1);
        check("rd_count_ch0", 32'(rd_cnt[0]), 32'd94);
        check("q_empty_t1", 32'(q.size()), 32'd0);

        // Reset, then all requesters held: grants 0,1,2,3,0 with one idle cycle between frames.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        eof_seen = 0; have_eof = 0; gap_chk = 1;
        for (int c = 0; c < 4; c++) exp_pkt[c] = 0;
        tick();
        push_frame(0, 94); push_frame(1, 94); push_frame(2, 94); push_frame(3, 94); push_frame(0, 94);
        src_req = 4'b1111;
        wait_eofs(5);
        src_req = 4'b0000;
        gap_chk = 0;
        check("q_empty_t2", 32'(q.size()), 32'd0);
        tick(); tick();

        // Back-pressure at payload word 10 of channel 1.
        p = exp_pkt[1];
        push_frame(1, 94);
        src_req = 4'b0010;
        wait_busy();
        src_req = 4'b0000;
        n = 0;
        while (w[1] != 10 && n < 200) begin tick(); n++; end
        check("reach_word10", 32'(w[1]), 32'd10);
        TX_DST_RDY_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_tx_d", 32'(TX_D), 32'(pw(1, p, 10)));
            check("stall_src_rd", 32'(src_rd), 32'd0);
            check("stall_eof_n", 32'(TX_EOF_N), 32'd1);
        end
        TX_DST_RDY_N = 1'b0;
        wait_eofs(6);
        check("q_empty_t3", 32'(q.size()), 32'd0);
        tick();

        // Channel drop mid-frame on channel 2; channel 3 must win afterwards.
        push_frame(2, 51);
        src_req = 4'b0100;
        wait_busy();
        src_req = 4'b0000;
        n = 0;
        while (w[2] != 50 && n < 200) begin tick(); n++; end
        check("reach_word50", 32'(w[2]), 32'd50);
        CHANNEL_UP = 1'b0;
        tick();
        check("abort_pulse", 32'(src_abort), 32'b0100);
        check("abort_src_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("q_empty_t4", 32'(q.size()), 32'd0);
        tick();
        check("abort_one_cycle", 32'(src_abort), 32'd0);
        CHANNEL_UP = 1'b1;
        push_frame(3, 94);
        src_req = 4'b1101;
        wait_busy();
        check("post_abort_grant", 32'(cur_chn), 32'd3);
        src_req = 4'b0000;
        wait_eofs(7);
        check("q_empty_t5", 32'(q.size()), 32'd0);
`ifdef AURORA_TX_STAT_EN
        check("stat_pkt_cnt", 32'(tx_pkt_cnt), 32'd7);
        check("stat_abort_cnt", 32'(tx_abort_cnt), 32'd1);
`endif
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
